// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
//   Packs a 32-bit immediate into the immediate fields of a RISC-V
//   instruction template (I/S/B/U/J formats). This is the inverse of the
//   immediate extender. Immediates that cannot be represented in the
//   selected format are flagged, and the template is passed through
//   unchanged.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake (in_ready is combinational)
//   base_instr, imm        instruction template and immediate to insert
//   ImmSrc                 000 I, 001 S, 010 B, 011 U, 100 J, others invalid
//   out_valid / out_ready  result handshake (registered output stage)
//   out_instr, out_err     encoded instruction, not-encodable flag
//   clr                    synchronous clear of the counters and the sticky flag
//   err_sticky             set by any errored request since reset or clr
//   enc_count, err_count   saturating counts of accepted and errored requests
// ---------------------------------------------------------------------------
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      base_instr,
    input  logic [31:0]      imm,
    input  logic [2:0]       ImmSrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    input  logic             clr,
    output logic             err_sticky,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_U = 3'b011;
    localparam logic [2:0] FMT_J = 3'b100;

    // Returns {err, instr}. On error the template is returned untouched.
    function automatic logic [32:0] encode(input logic [31:0] b,
                                           input logic [31:0] v,
                                           input logic [2:0]  fmt);
        logic        ok;
        logic [31:0] ins;
        ok  = 1'b0;
        ins = b;
        case (fmt)
            FMT_I: begin
                ok  = (v[31:11] == {21{v[31]}});
                ins = {v[11:0], b[19:0]};
            end
            FMT_S: begin
                ok  = (v[31:11] == {21{v[31]}});
                ins = {v[11:5], b[24:12], v[4:0], b[6:0]};
            end
            FMT_B: begin
                ok  = (v[31:12] == {20{v[31]}}) && !v[0];
                ins = {v[12], v[10:5], b[24:12], v[4:1], v[11], b[6:0]};
            end
            FMT_U: begin
                ok  = (v[11:0] == 12'h000);
                ins = {v[31:12], b[11:0]};
            end
            FMT_J: begin
                ok  = (v[31:20] == {12{v[31]}}) && !v[0];
                ins = {v[20], v[10:1], v[11], v[19:12], b[11:0]};
            end
            default: begin
                ok  = 1'b0;
                ins = b;
            end
        endcase
        return ok ? {1'b0, ins} : {1'b1, b};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic        accept;
    logic [32:0] enc_p0;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign enc_p0   = encode(base_instr, imm, ImmSrc);

    // ---- output register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= enc_p0[31:0];
            out_err   <= enc_p0[32];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Statistics: clr takes priority over a same-cycle acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            enc_count  <= '0;
            err_count  <= '0;
        end else if (clr) begin
            err_sticky <= 1'b0;
            enc_count  <= '0;
            err_count  <= '0;
        end else if (accept) begin
            enc_count <= sat_inc(enc_count);
            if (enc_p0[32]) begin
                err_count  <= sat_inc(err_count);
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_encoder
//   Scoreboard bench for imm_encoder. The driver pushes the reference
//   model's result for every accepted request; a monitor pops and compares
//   whenever a result is transferred. The reference model writes the
//   immediate bits via a per-format bit map and decides representability by
//   decoding the result with the standard immediate extender and comparing
//   it with the original immediate.
// ---------------------------------------------------------------------------
module tb_imm_encoder;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      base_instr;
    logic [31:0]      imm;
    logic [2:0]       ImmSrc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic             clr;
    logic             err_sticky;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .base_instr (base_instr),
        .imm        (imm),
        .ImmSrc     (ImmSrc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .clr        (clr),
        .err_sticky (err_sticky),
        .enc_count  (enc_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_push = 0;
    int          n_pop = 0;
    logic [32:0] sb_q[$];

    // Counter / sticky model
    int          m_enc = 0;
    int          m_err = 0;
    logic        m_sticky = 1'b0;
    logic        rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Which immediate bit lands in instruction bit i (-1: template bit).
    function automatic int map_bit(input logic [2:0] f, input int i);
        case (f)
            3'd0: return (i >= 20) ? i - 20 : -1;
            3'd1: begin
                if (i >= 25) return i - 20;
                if (i >= 7 && i <= 11) return i - 7;
                return -1;
            end
            3'd2: begin
                if (i == 31) return 12;
                if (i >= 25) return i - 20;
                if (i >= 8 && i <= 11) return i - 7;
                if (i == 7) return 11;
                return -1;
            end
            3'd3: return (i >= 12) ? i : -1;
            3'd4: begin
                if (i == 31) return 20;
                if (i >= 21) return i - 20;
                if (i == 20) return 11;
                if (i >= 12) return i;
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    // Standard immediate extender.
    function automatic logic [31:0] decode(input logic [31:0] x, input logic [2:0] f);
        case (f)
            3'd0: return {{20{x[31]}}, x[31:20]};
            3'd1: return {{20{x[31]}}, x[31:25], x[11:7]};
            3'd2: return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            3'd3: return {x[31:12], 12'h000};
            3'd4: return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [32:0] model(input logic [31:0] b, input logic [31:0] v,
                                          input logic [2:0] f);
        logic [31:0] e;
        int          j;
        if (f > 3'd4) return {1'b1, b};
        e = b;
        for (int i = 0; i < 32; i++) begin
            j = map_bit(f, i);
            if (j >= 0) e[i] = v[j];
        end
        if (decode(e, f) != v) return {1'b1, b};
        return {1'b0, e};
    endfunction

    // Monitor: a result is transferred at the next rising edge.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got 0x%08h err=%0b, queue empty", out_instr, out_err);
            end else begin
                e = sb_q.pop_front();
                n_pop++;
                chk("out_instr", out_instr, e[31:0]);
                chk("out_err", {31'h0, out_err}, {31'h0, e[32]});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1. Waits (bounded) for acceptance.
    task automatic send(input logic [31:0] b, input logic [31:0] v,
                        input logic [2:0] f, input logic c);
        logic        acc;
        logic [32:0] r;
        base_instr = b;
        imm        = v;
        ImmSrc     = f;
        in_valid   = 1'b1;
        clr        = c;
        acc        = 1'b0;
        r          = model(b, v, f);
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (c) begin
                m_enc = 0; m_err = 0; m_sticky = 1'b0;
            end else if (acc) begin
                if (m_enc < int'(CMAX)) m_enc++;
                if (r[32]) begin
                    if (m_err < int'(CMAX)) m_err++;
                    m_sticky = 1'b1;
                end
            end
        end
        clr = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 50 cycles");
        end else begin
            sb_q.push_back(r);
            n_push++;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_enc_count"}, 32'(enc_count), 32'(m_enc));
        chk({tag, "_err_count"}, 32'(err_count), 32'(m_err));
        chk({tag, "_err_sticky"}, {31'h0, err_sticky}, {31'h0, m_sticky});
    endtask

    // Directed send with immediate check of the DUT output (out_ready=1).
    task automatic send_expect(input logic [31:0] b, input logic [31:0] v, input logic [2:0] f,
                               input logic [31:0] ei, input logic ee, input string name);
        send(b, v, f, 1'b0);
        chk({name, "_instr"}, out_instr, ei);
        chk({name, "_err"}, {31'h0, out_err}, {31'h0, ee});
        chk({name, "_valid"}, {31'h0, out_valid}, 32'h1);
        check_stats(name);
    endtask

    initial begin
        logic [32:0] held;
        logic [31:0] r;
        logic [31:0] v;
        logic [2:0]  f;

        rst_n = 1'b0; in_valid = 1'b0; base_instr = 32'h0; imm = 32'h0;
        ImmSrc = 3'h0; out_ready = 1'b1; clr = 1'b0;
        #12;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_err", {31'h0, out_err}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check_stats("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed encodings
        send_expect(32'h00000013, 32'hFFFFFFFF, 3'b000, 32'hFFF00013, 1'b0, "i_neg1");
        send_expect(32'h00000063, 32'hFFFFFFFE, 3'b010, 32'hFE000FE3, 1'b0, "b_neg2");
        send_expect(32'h00000063, 32'h00001000, 3'b010, 32'h00000063, 1'b1, "b_range");
        send_expect(32'h0000006F, 32'h000FFFFE, 3'b100, 32'h7FFFF06F, 1'b0, "j_max");
        send_expect(32'h0000006F, 32'h00000003, 3'b100, 32'h0000006F, 1'b1, "j_odd");
        send_expect(32'h00000537, 32'h12345000, 3'b011, 32'h12345537, 1'b0, "u_ok");
        send_expect(32'h00000537, 32'h12345001, 3'b011, 32'h00000537, 1'b1, "u_low");
        send_expect(32'h00000537, 32'h00000000, 3'b111, 32'h00000537, 1'b1, "bad_fmt");
        send_expect(32'h00000023, 32'hFFFFF800, 3'b001, 32'h80000023, 1'b0, "s_min");
        send_expect(32'h00000023, 32'h00000800, 3'b001, 32'h00000023, 1'b1, "s_range");
        idle();

        // Backpressure: result A stalls, B waits with in_valid held
        out_ready = 1'b0;
        send(32'h00000013, 32'h00000123, 3'b000, 1'b0);
        held = model(32'h00000013, 32'h00000123, 3'b000);
        base_instr = 32'h00000023; imm = 32'h00000045; ImmSrc = 3'b001; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_out_instr", out_instr, held[31:0]);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h00000023, 32'h00000045, 3'b001, 1'b0);
        for (int k = 0; k < 8; k++) begin
            r = $urandom;
            send(r, {{20{r[9]}}, r[11:0]}, 3'b000, 1'b0);
        end
        idle();
        idle();
        chk("bp_drain", 32'(sb_q.size()), 32'h0);

        // clr together with an errored acceptance
        send(32'h00000063, 32'h00000001, 3'b010, 1'b1);
        chk("clr_out_err", {31'h0, out_err}, 32'h1);
        chk("clr_out_instr", out_instr, 32'h00000063);
        check_stats("clr");
        chk("clr_sticky_zero", {31'h0, err_sticky}, 32'h0);
        idle();

        // Saturation: every request errors so both counters saturate
        for (int k = 0; k < (1 << CNT_W) + 5; k++)
            send(32'h00000013 + k, 32'h0, 3'b110, 1'b0);
        idle();
        check_stats("sat");
        chk("sat_enc_max", 32'(enc_count), 32'(CMAX));
        chk("sat_err_max", 32'(err_count), 32'(CMAX));

        // Randomized traffic with random backpressure and occasional clr
        rand_rdy = 1'b1;
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: begin
                    v = {{19{r[12]}}, r[12:0]};
                    if ($urandom_range(0, 1) == 1) v[0] = 1'b0;
                end
                2: v = r & 32'hFFFFF000;
                default: v = {{11{r[20]}}, r[20:1], 1'b0};
            endcase
            f = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            send($urandom, v, f, ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 3) == 0) idle();
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        idle();
        idle();
        check_stats("rand");
        chk("rand_drain", 32'(sb_q.size()), 32'h0);
        chk("push_pop", 32'(n_pop), 32'(n_push));

        // Asynchronous reset while a result is stalled
        out_ready = 1'b0;
        send(32'h00000013, 32'h00000007, 3'b000, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("async_rst_instr", out_instr, 32'h0);
        chk("async_rst_enc", 32'(enc_count), 32'h0);
        chk("async_rst_sticky", {31'h0, err_sticky}, 32'h0);
        sb_q.delete();
        m_enc = 0; m_err = 0; m_sticky = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_expect(32'h00000013, 32'h00000005, 3'b000, 32'h00500013, 1'b0, "post_rst");
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate extender: packs a 32-bit immediate into the immediate bit fields of a RISC-V instruction word, selected by ImmSrc.
- Used by the instruction-memory loader and branch/jump fix-up path to patch offsets into pre-built instructions.
- Checks that each immediate is representable in its format; unrepresentable values are flagged.
- Valid/ready streaming with a registered output stage, a sticky error flag and saturating statistics counters.

Parameters:
- CNT_W, 16, width of the enc_count and err_count counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- base_instr  input  32  instruction template; bits outside the selected immediate fields pass through
- imm  input  32  immediate value to encode
- ImmSrc  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J; others invalid
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_instr  output  32  encoded instruction
- out_err  output  1  result was not encodable; out_instr equals base_instr
- clr  input  1  synchronous clear of counters and sticky flag
- err_sticky  output  1  set by any errored request since reset or clr
- enc_count  output  CNT_W  requests accepted, saturating
- err_count  output  CNT_W  errored requests accepted, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_instr=0, out_err=0, err_sticky=0, enc_count=0, err_count=0. in_ready=1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A request is accepted on a clock edge where in_valid && in_ready.
  - Latency is 1 cycle. Throughput is 1 request per cycle while out_ready=1.
  - When out_valid=1 and out_ready=0, out_instr and out_err hold stable and in_ready=0.
  - At a clock edge with out_valid && out_ready and no new acceptance, out_valid drops to 0.
- Field packing (all other bits come from base_instr):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
- Representability (error if the condition fails):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - Any ImmSrc value 101–111 is always an error.
- On error: out_instr=base_instr unchanged and out_err=1.
- Round-trip property: for any non-error result, sign/zero-extending out_instr with the same ImmSrc returns imm exactly.
- Counters and sticky flag:
  - On acceptance: enc_count+1; if errored, also err_count+1 and err_sticky=1.
  - Both counters saturate at all-ones; no wrap.
- clr:
  - Clears enc_count, err_count and err_sticky next edge.
  - If a request is accepted in the same cycle, clr wins: that request is not counted and sets no sticky, but its result is still produced normally.
  - clr does not affect the datapath or the handshake.
- Reset asserted mid-transfer: the pending result is discarded immediately (out_valid=0). No partial state survives.
- All outputs are registered except in_ready.

Test Plan:
- Reset, then send ImmSrc=000, base=0x00000013, imm=0xFFFFFFFF -> one cycle later out_instr=0xFFF00013, out_err=0, enc_count=1.
- Send ImmSrc=010, base=0x00000063, imm=0xFFFFFFFE -> out_instr=0xFE000FE3. Then imm=0x00001000 -> out_err=1, out_instr=0x00000063, err_sticky=1, err_count=1.
- Send ImmSrc=100, base=0x0000006F, imm=0x000FFFFE -> out_instr=0x7FFFF06F. Then imm=0x00000003 -> out_err=1.
- Send ImmSrc=011, imm=0x12345000, base=0x00000537 -> 0x12345537. Then imm=0x12345001 -> out_err=1. Then ImmSrc=111 -> out_err=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr stable. Release -> one result per cycle, no loss or duplicate over 8 back-to-back requests.
- Pulse clr in the same cycle as an errored acceptance -> counters and err_sticky read 0, out_err=1 still delivered. Drive 2^CNT_W+5 requests -> enc_count saturates at all-ones. Assert rst_n=0 with out_valid=1 -> out_valid=0 asynchronously.
